stochastic_bitstream_encoder: RTL and testbench
===============================================

// Module: stochastic_bitstream_encoder
// PURPOSE
//  Converts binary probability words from the input AXI-Stream FIFO path into parallel stochastic bitstreams.
//  Consumes fifo_2_axis_adapter-style AXIS words; feeds the stochastic neuron array one bit vector per handshake.
//  Each word packs NUM_CHANNELS values. Each value becomes i_stream_len comparator bits from a per-channel LFSR.
// PARAMETERS
//  AXIS_DATA_WIDTH   32       input word width
//  VALUE_WIDTH       8        bits per channel value; must be <= 16
//  NUM_CHANNELS      AXIS_DATA_WIDTH/VALUE_WIDTH   channels per word; value c = tdata[c*VALUE_WIDTH +: VALUE_WIDTH]
//  LEN_WIDTH         16       width of stream-length input
//  LFSR_SEED         16'hACE1 base seed; channel c seed = LFSR_SEED ^ (c*16'h1F35); a zero seed is replaced by 16'h0001
// PORTS
//  clk               in   1                 clock
//  rst               in   1                 synchronous, active-high reset
//  i_stream_len      in   LEN_WIDTH         bits per word; sampled on word accept
//  i_axis_tuser      in   1                 word user flag
//  i_axis_tvalid     in   1                 word valid
//  o_axis_tready     out  1                 word ready
//  i_axis_tlast      in   1                 last word of packet
//  i_axis_tdata      in   AXIS_DATA_WIDTH   packed channel values
//  o_bits_valid      out  1                 bit vector valid
//  i_bits_ready      in   1                 downstream ready
//  o_bits            out  NUM_CHANNELS      one stochastic bit per channel
//  o_bits_user       out  1                 tuser of the word being encoded
//  o_bits_last       out  1                 final bit of current word
//  o_bits_tlast      out  1                 final bit of final word of packet (o_bits_last && word tlast)
//  o_busy            out  1                 state != IDLE
// BEHAVIOUR
//  Reset: every output is 0, including o_axis_tready. State is IDLE. LFSRs are loaded with their seeds. Counters are cleared.
//  States:
//   IDLE: o_axis_tready=1. On tvalid, latch data/user/tlast and len (len 0 is treated as 1) -> RUN.
//   RUN: o_bits_valid=1. Each handshake (valid&&ready) decrements remaining count and advances all LFSRs one step.
//  End of word:
//   o_bits_last=1 while remaining==1.
//   o_axis_tready = IDLE || (RUN && remaining==1 && i_bits_ready). A new word is accepted on the final handshake, with no bubble.
//   Final handshake with no word accepted -> IDLE.
//  Latency: word accepted at cycle N -> first o_bits_valid at N+1. Outputs are registered.
//  Stall: while o_bits_valid && !i_bits_ready, o_bits/user/last/tlast are held and LFSRs are frozen.
//   The emitted sequence is therefore independent of backpressure.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1), one per channel.
//   LFSRs are never reseeded between words; only rst reseeds them.
//  Bit rule: o_bits[c] = (lfsr_c[VALUE_WIDTH-1:0] < v_c), unsigned compare.
//   v=0 always yields 0. P(1) is approximately v/2^VALUE_WIDTH.
//  o_bits is computed from the LFSR state before the advance, and is registered into the output stage on load/handshake.
//  rst mid-word: the word is discarded, o_bits_valid=0 on the next cycle, and the sequence restarts from the seeds.
//  i_stream_len changes during RUN have no effect until the next accept.
// CONFIGURATION
//  STOCH_ENC_BIPOLAR_EN defined: values are signed two's complement.
//   v_c = value ^ (1<<(VALUE_WIDTH-1)), i.e. MSB flipped. P(1) = (x+1)/2 bipolar encoding. 8'h80 -> never 1; 8'h00 -> ~50%.
//  Undefined: unipolar unsigned encoding as above. No other logic differs.
// TESTING
//  1 Reset: hold rst 3 cycles -> all outputs 0. Cycle after release: o_axis_tready=1, o_bits_valid=0.
//  2 tdata=0, len=16, ready=1 -> exactly 16 valid cycles, o_bits=0 on each, o_bits_last only on the 16th, then IDLE.
//  3 tdata=32'h80808080, len=1024, ready=1 (unipolar) -> per-channel ones count in [480,544]. The 4 channel sequences differ.
//  4 Two back-to-back words, len=4, second with tlast, ready=1 -> 8 consecutive valid cycles, no bubble.
//    o_bits_last on cycles 4 and 8. o_bits_tlast only on cycle 8.
//  5 Repeat test 3 with i_bits_ready randomly deasserted 50% -> outputs stable during every stall.
//    Bit sequence identical to test 3 (compare against reference LFSR model).
//  6 rst asserted after 3 of 10 bits; then resend the same word -> valid drops the cycle after rst.
//    New sequence equals the first 10 bits of a fresh post-reset run. Also len=0 -> exactly 1 bit emitted.

Source files
------------

// File: rtl/stochastic_bitstream_encoder_if.sv
// Bus bundle for stochastic_bitstream_encoder: the AXI-Stream word input,
// the stream-length control and the parallel bit-vector output.
// The slave modport is the encoder's view; the master modport is the
// view of the logic that feeds words in and drains bit vectors.
interface stochastic_bitstream_encoder_if #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int NUM_CHANNELS    = 4,
    parameter int LEN_WIDTH       = 16
);
    logic [LEN_WIDTH-1:0]       i_stream_len;
    logic                       i_axis_tuser;
    logic                       i_axis_tvalid;
    logic                       o_axis_tready;
    logic                       i_axis_tlast;
    logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata;
    logic                       o_bits_valid;
    logic                       i_bits_ready;
    logic [NUM_CHANNELS-1:0]    o_bits;
    logic                       o_bits_user;
    logic                       o_bits_last;
    logic                       o_bits_tlast;
    logic                       o_busy;

    modport slave (
        input  i_stream_len,
        input  i_axis_tuser,
        input  i_axis_tvalid,
        output o_axis_tready,
        input  i_axis_tlast,
        input  i_axis_tdata,
        output o_bits_valid,
        input  i_bits_ready,
        output o_bits,
        output o_bits_user,
        output o_bits_last,
        output o_bits_tlast,
        output o_busy
    );

    modport master (
        output i_stream_len,
        output i_axis_tuser,
        output i_axis_tvalid,
        input  o_axis_tready,
        output i_axis_tlast,
        output i_axis_tdata,
        input  o_bits_valid,
        output i_bits_ready,
        input  o_bits,
        input  o_bits_user,
        input  o_bits_last,
        input  o_bits_tlast,
        input  o_busy
    );
endinterface

// File: rtl/stochastic_bitstream_encoder.sv
// stochastic_bitstream_encoder
// Turns each AXIS word of NUM_CHANNELS packed probability values into
// i_stream_len parallel stochastic bit vectors. Every channel owns a 16-bit
// Fibonacci LFSR (x^16+x^14+x^13+x^11+1); a bit is 1 when the low
// VALUE_WIDTH bits of the LFSR are below the channel value. LFSRs only
// advance when a new bit is loaded into the output stage, so the emitted
// sequence does not depend on backpressure. Only rst reseeds them.
// Optional macro STOCH_ENC_BIPOLAR_EN: values are read as signed two's
// complement and mapped to bipolar encoding by flipping their MSB.
module stochastic_bitstream_encoder #(
    parameter int          AXIS_DATA_WIDTH = 32,
    parameter int          VALUE_WIDTH     = 8,
    parameter int          NUM_CHANNELS    = AXIS_DATA_WIDTH / VALUE_WIDTH,
    parameter int          LEN_WIDTH       = 16,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    stochastic_bitstream_encoder_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1'b1);
    localparam logic [LEN_WIDTH-1:0] LEN_TWO = LEN_WIDTH'(2'd2);

    // Per-channel seed; an all-zero seed would lock the LFSR, so it is replaced.
    function automatic logic [15:0] f_seed(input int c);
        logic [15:0] s;
        s = LFSR_SEED ^ 16'(c * 32'h0000_1F35);
        if (s == 16'h0000) begin
            s = 16'h0001;
        end else begin
            s = s;
        end
        return s;
    endfunction

    // One Fibonacci step, taps 16,14,13,11 in right-shifting form.
    function automatic logic [15:0] f_lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Map a raw channel value onto the unsigned comparison threshold.
    function automatic logic [VALUE_WIDTH-1:0] f_polar(input logic [VALUE_WIDTH-1:0] value);
`ifdef STOCH_ENC_BIPOLAR_EN
        return value ^ {1'b1, {(VALUE_WIDTH-1){1'b0}}};
`else
        return value;
`endif
    endfunction

    state_t                     r_state;
    state_t                     w_state_next;
    logic [AXIS_DATA_WIDTH-1:0] r_data;
    logic                       r_tlast;
    logic [LEN_WIDTH-1:0]       r_rem;
    logic [15:0]                r_lfsr      [NUM_CHANNELS];
    logic [15:0]                w_lfsr_next [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]    r_bits;
    logic                       r_bits_valid;
    logic                       r_bits_user;
    logic                       r_bits_last;
    logic                       r_bits_tlast;
    logic [NUM_CHANNELS-1:0]    w_bits_new;
    logic [NUM_CHANNELS-1:0]    w_bits_cur;
    logic [LEN_WIDTH-1:0]       w_len_eff;
    logic                       w_tready;
    logic                       w_accept;
    logic                       w_hs;
    logic                       w_step;
    logic                       w_done;

    assign w_len_eff = (bus.i_stream_len == {LEN_WIDTH{1'b0}}) ? LEN_ONE : bus.i_stream_len;
    assign w_hs      = r_bits_valid && bus.i_bits_ready;
    assign w_accept  = bus.i_axis_tvalid && w_tready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a word moves IDLE->RUN; the last bit without a follow-on word returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_done) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: word-ready (opens on the final handshake for bubble-free chaining) and datapath strobes.
    always_comb begin
        w_tready = 1'b0;
        w_step   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tready = !rst;
            end
            ST_RUN: begin
                w_tready = !rst && (r_rem == LEN_ONE) && bus.i_bits_ready;
                w_step   = w_hs && (r_rem != LEN_ONE);
                w_done   = w_hs && (r_rem == LEN_ONE) && !w_accept;
            end
            default: begin
                w_tready = 1'b0;
            end
        endcase
    end

    // Comparator bits for a freshly accepted word and for the word in flight, plus next LFSR states.
    always_comb begin
        w_bits_new = {NUM_CHANNELS{1'b0}};
        w_bits_cur = {NUM_CHANNELS{1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_lfsr_next[c] = f_lfsr_step(r_lfsr[c]);
            w_bits_new[c]  = (r_lfsr[c][VALUE_WIDTH-1:0] <
                              f_polar(bus.i_axis_tdata[c*VALUE_WIDTH +: VALUE_WIDTH]));
            w_bits_cur[c]  = (r_lfsr[c][VALUE_WIDTH-1:0] <
                              f_polar(r_data[c*VALUE_WIDTH +: VALUE_WIDTH]));
        end
    end

    // Word latch, remaining count, LFSRs and output stage; everything holds during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= {AXIS_DATA_WIDTH{1'b0}};
            r_tlast      <= 1'b0;
            r_rem        <= {LEN_WIDTH{1'b0}};
            r_bits       <= {NUM_CHANNELS{1'b0}};
            r_bits_valid <= 1'b0;
            r_bits_user  <= 1'b0;
            r_bits_last  <= 1'b0;
            r_bits_tlast <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_lfsr[c] <= f_seed(c);
            end
        end else if (w_accept) begin
            r_data       <= bus.i_axis_tdata;
            r_tlast      <= bus.i_axis_tlast;
            r_rem        <= w_len_eff;
            r_bits       <= w_bits_new;
            r_bits_valid <= 1'b1;
            r_bits_user  <= bus.i_axis_tuser;
            r_bits_last  <= (w_len_eff == LEN_ONE);
            r_bits_tlast <= (w_len_eff == LEN_ONE) && bus.i_axis_tlast;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_lfsr[c] <= w_lfsr_next[c];
            end
        end else if (w_step) begin
            r_rem        <= r_rem - LEN_ONE;
            r_bits       <= w_bits_cur;
            r_bits_last  <= (r_rem == LEN_TWO);
            r_bits_tlast <= (r_rem == LEN_TWO) && r_tlast;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_lfsr[c] <= w_lfsr_next[c];
            end
        end else if (w_done) begin
            r_rem        <= {LEN_WIDTH{1'b0}};
            r_bits       <= {NUM_CHANNELS{1'b0}};
            r_bits_valid <= 1'b0;
            r_bits_user  <= 1'b0;
            r_bits_last  <= 1'b0;
            r_bits_tlast <= 1'b0;
        end else begin
            r_rem <= r_rem;
        end
    end

    assign bus.o_axis_tready = w_tready;
    assign bus.o_bits_valid  = r_bits_valid;
    assign bus.o_bits        = r_bits;
    assign bus.o_bits_user   = r_bits_user;
    assign bus.o_bits_last   = r_bits_last;
    assign bus.o_bits_tlast  = r_bits_tlast;
    assign bus.o_busy        = (r_state == ST_RUN);

endmodule

// File: tb/tb_stochastic_bitstream_encoder.sv
// Directed self-checking bench for stochastic_bitstream_encoder (unipolar build).
module tb_stochastic_bitstream_encoder;
    localparam int DW = 32;
    localparam int VW = 8;
    localparam int NC = 4;
    localparam int LW = 16;

    typedef struct packed {
        logic [NC-1:0] bits;
        logic          user;
        logic          last;
        logic          tlast;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rand_ready = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    stochastic_bitstream_encoder_if #(.AXIS_DATA_WIDTH(DW), .NUM_CHANNELS(NC), .LEN_WIDTH(LW)) bus ();

    stochastic_bitstream_encoder #(
        .AXIS_DATA_WIDTH(DW), .VALUE_WIDTH(VW), .NUM_CHANNELS(NC),
        .LEN_WIDTH(LW), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Monitor: logs every handshaken bit vector and checks outputs hold during stalls.
    ent_t log_q[$];
    int   vcyc_q[$];
    int   cyc = 0;
    int   stall_cnt = 0;
    int   stall_bad = 0;
    logic prev_stall = 1'b0;
    ent_t held;
    ent_t mon_cur;
    assign mon_cur = {bus.o_bits, bus.o_bits_user, bus.o_bits_last, bus.o_bits_tlast};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.o_bits_valid) vcyc_q.push_back(cyc);
            if (bus.o_bits_valid && bus.i_bits_ready) log_q.push_back(mon_cur);
            if (prev_stall) begin
                stall_cnt <= stall_cnt + 1;
                if (!bus.o_bits_valid || mon_cur != held) stall_bad <= stall_bad + 1;
            end
            prev_stall <= bus.o_bits_valid && !bus.i_bits_ready;
            held       <= mon_cur;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR model, seeds worked out by hand from 16'hACE1 ^ c*16'h1F35.
    logic [15:0] m_lfsr [NC];

    task automatic model_reseed();
        m_lfsr[0] = 16'hACE1;
        m_lfsr[1] = 16'hB3D4;
        m_lfsr[2] = 16'h928B;
        m_lfsr[3] = 16'hF17E;
    endtask

    task automatic model_bits(input logic [DW-1:0] d, output logic [NC-1:0] b);
        for (int c = 0; c < NC; c++) begin
            b[c] = (m_lfsr[c][7:0] < d[c*VW +: VW]);
            m_lfsr[c] = {m_lfsr[c][0] ^ m_lfsr[c][2] ^ m_lfsr[c][3] ^ m_lfsr[c][5], m_lfsr[c][15:1]};
        end
    endtask

    // Compare n logged entries from base with the model; first nsplit use d0, the rest d1.
    task automatic check_seq(input string tag, input int base, input int n,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int nsplit);
        int bad = 0;
        logic [NC-1:0] e;
        for (int i = 0; i < n; i++) begin
            model_bits((i < nsplit) ? d0 : d1, e);
            if (base + i >= log_q.size()) bad++;
            else if (log_q[base+i].bits !== e) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_bits_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_axis_tvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        model_reseed();
    endtask

    task automatic accept_word(input logic [DW-1:0] d, input logic u, input logic l,
                               input logic [LW-1:0] len, input string tag);
        bit done = 1'b0;
        bus.i_axis_tdata  = d;
        bus.i_axis_tuser  = u;
        bus.i_axis_tlast  = l;
        bus.i_stream_len  = len;
        bus.i_axis_tvalid = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            #1;
            if (bus.o_axis_tready) done = 1'b1;
            tick();
        end
        bus.i_axis_tvalid = 1'b0;
        if (!done) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while (bus.o_busy && k < limit) begin
            tick();
            k++;
        end
        if (bus.o_busy) chk({tag, "_idle_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, vbase, nl, sbase, sbad;
        int ones [NC];
        logic [7:0] mlast, mtlast, muser;
        ent_t t3_q[$];
        logic [NC-1:0] e;

        bus.i_stream_len  = 16'd0;
        bus.i_axis_tuser  = 1'b0;
        bus.i_axis_tvalid = 1'b0;
        bus.i_axis_tlast  = 1'b0;
        bus.i_axis_tdata  = 32'd0;
        bus.i_bits_ready  = 1'b1;

        // T1: reset held three cycles, all outputs zero; ready one cycle after release.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_rst_outs", {bus.o_axis_tready, bus.o_bits_valid, bus.o_bits, bus.o_bits_user,
                                bus.o_bits_last, bus.o_bits_tlast, bus.o_busy}, 64'd0);
        end
        rst = 1'b0;
        model_reseed();
        tick();
        chk("t1_tready_after", bus.o_axis_tready, 64'd1);
        chk("t1_valid_after", bus.o_bits_valid, 64'd0);

        // T2: zero word, len 16 -> 16 zero bits, last only on the 16th.
        base  = log_q.size();
        vbase = vcyc_q.size();
        accept_word(32'h0000_0000, 1'b0, 1'b0, 16'd16, "t2");
        chk("t2_latency_valid", bus.o_bits_valid, 64'd1);
        wait_idle("t2", 100);
        chk("t2_count", log_q.size() - base, 64'd16);
        chk("t2_valid_cycles", vcyc_q.size() - vbase, 64'd16);
        nl = 0;
        e  = '0;
        for (int i = base; i < log_q.size(); i++) begin
            e  = e | log_q[i].bits;
            nl = nl + int'(log_q[i].last);
        end
        chk("t2_bits_zero", e, 64'd0);
        chk("t2_last_count", nl, 64'd1);
        if (log_q.size() >= base + 16) chk("t2_last_on_16", log_q[base+15].last, 64'd1);
        else chk("t2_last_on_16", 64'd0, 64'd1);
        chk("t2_idle_tready", {bus.o_busy, bus.o_axis_tready}, 64'd1);
        check_seq("t2_seq", base, 16, 32'h0, 32'h0, 16);

        // T3: 0x80 in every channel, len 1024 -> about half ones, distinct channel sequences.
        do_reset();
        base = log_q.size();
        accept_word(32'h8080_8080, 1'b0, 1'b0, 16'd1024, "t3");
        wait_idle("t3", 1200);
        chk("t3_count", log_q.size() - base, 64'd1024);
        for (int c = 0; c < NC; c++) ones[c] = 0;
        for (int i = base; i < log_q.size(); i++) begin
            t3_q.push_back(log_q[i]);
            for (int c = 0; c < NC; c++) ones[c] += int'(log_q[i].bits[c]);
        end
        for (int c = 0; c < NC; c++) begin
            if (ones[c] < 480 || ones[c] > 544)
                $display("  t3 channel %0d ones = %0d", c, ones[c]);
            chk("t3_ones_in_range", (ones[c] >= 480 && ones[c] <= 544), 64'd1);
        end
        for (int a = 0; a < NC; a++) begin
            for (int b = a + 1; b < NC; b++) begin
                nl = 0;
                foreach (t3_q[i]) nl += int'(t3_q[i].bits[a] != t3_q[i].bits[b]);
                chk("t3_channels_differ", (nl > 0), 64'd1);
            end
        end
        check_seq("t3_seq", base, 1024, 32'h8080_8080, 32'h8080_8080, 1024);

        // T4: back-to-back len-4 words, second with tlast -> 8 consecutive bits.
        do_reset();
        base  = log_q.size();
        vbase = vcyc_q.size();
        accept_word(32'h80C0_D5FF, 1'b1, 1'b0, 16'd4, "t4a");
        accept_word(32'h1234_5678, 1'b0, 1'b1, 16'd4, "t4b");
        wait_idle("t4", 100);
        chk("t4_count", log_q.size() - base, 64'd8);
        chk("t4_valid_cycles", vcyc_q.size() - vbase, 64'd8);
        if (vcyc_q.size() >= vbase + 8) chk("t4_no_bubble", vcyc_q[vbase+7] - vcyc_q[vbase], 64'd7);
        else chk("t4_no_bubble", 64'd0, 64'd7);
        mlast = '0; mtlast = '0; muser = '0;
        for (int i = 0; i < 8 && base + i < log_q.size(); i++) begin
            mlast[i]  = log_q[base+i].last;
            mtlast[i] = log_q[base+i].tlast;
            muser[i]  = log_q[base+i].user;
        end
        chk("t4_last_mask", mlast, 64'h88);
        chk("t4_tlast_mask", mtlast, 64'h80);
        chk("t4_user_mask", muser, 64'h0F);
        if (log_q.size() > base) chk("t4_first_bits", log_q[base].bits, 64'hF);
        else chk("t4_first_bits", 64'd0, 64'hF);
        check_seq("t4_seq", base, 8, 32'h80C0_D5FF, 32'h1234_5678, 4);

        // T5: test 3 again with random backpressure -> identical sequence, stable stalls.
        do_reset();
        rand_ready = 1'b1;
        base  = log_q.size();
        sbase = stall_cnt;
        sbad  = stall_bad;
        accept_word(32'h8080_8080, 1'b0, 1'b0, 16'd1024, "t5");
        wait_idle("t5", 3000);
        rand_ready = 1'b0;
        tick();
        chk("t5_count", log_q.size() - base, 64'd1024);
        nl = 0;
        foreach (t3_q[i]) begin
            if (base + i >= log_q.size()) nl++;
            else if (log_q[base+i] !== t3_q[i]) nl++;
        end
        chk("t5_same_as_t3", nl, 64'd0);
        chk("t5_stalls_seen", (stall_cnt - sbase > 0), 64'd1);
        chk("t5_stall_stable", stall_bad - sbad, 64'd0);
        check_seq("t5_seq", base, 1024, 32'h8080_8080, 32'h8080_8080, 1024);

        // T6: reset after 3 of 10 bits, resend -> fresh sequence; then len 0 -> one bit.
        do_reset();
        base = log_q.size();
        accept_word(32'h7E8B_D5E2, 1'b0, 1'b0, 16'd10, "t6a");
        for (int k = 0; k < 50 && log_q.size() < base + 3; k++) tick();
        chk("t6_three_bits", log_q.size() - base, 64'd3);
        rst = 1'b1;
        tick();
        chk("t6_valid_drop", {bus.o_bits_valid, bus.o_busy}, 64'd0);
        rst = 1'b0;
        model_reseed();
        base = log_q.size();
        accept_word(32'h7E8B_D5E2, 1'b0, 1'b0, 16'd10, "t6b");
        wait_idle("t6b", 100);
        chk("t6_count", log_q.size() - base, 64'd10);
        if (log_q.size() > base) chk("t6_first_bits", log_q[base].bits, 64'h3);
        else chk("t6_first_bits", 64'd0, 64'h3);
        check_seq("t6_seq", base, 10, 32'h7E8B_D5E2, 32'h7E8B_D5E2, 10);

        base = log_q.size();
        accept_word(32'h7E8B_D5E2, 1'b1, 1'b1, 16'd0, "t6z");
        wait_idle("t6z", 20);
        chk("t6_len0_count", log_q.size() - base, 64'd1);
        if (log_q.size() > base)
            chk("t6_len0_flags", {log_q[base].user, log_q[base].last, log_q[base].tlast}, 64'h7);
        else chk("t6_len0_flags", 64'd0, 64'h7);
        check_seq("t6_len0_seq", base, 1, 32'h7E8B_D5E2, 32'h7E8B_D5E2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
